// File: rtl/sid_svf_tdm_pkg.sv
// rtl/sid_svf_tdm_pkg.sv - shared types and constants for the TDM state-variable filter
// Purpose: mode bit positions, FSM state encoding, registered request fields
//          that do not depend on the sample width, and fixed-point fraction sizes.
package sid_svf_tdm_pkg;

  localparam int SVF_W0_FRAC = 17;
  localparam int SVF_Q_FRAC  = 10;

  // Bit positions of the filter outputs inside mode_i ({HP,BP,LP}).
  typedef enum logic [1:0] {
    SVF_LP = 2'd0,
    SVF_BP = 2'd1,
    SVF_HP = 2'd2
  } svf_mode_t;

  typedef enum logic [2:0] {
    SVF_S_IDLE = 3'd0,
    SVF_S_LP   = 3'd1,
    SVF_S_BP   = 3'd2,
    SVF_S_HP   = 3'd3,
    SVF_S_MIX  = 3'd4,
    SVF_S_VOL  = 3'd5,
    SVF_S_OUT  = 3'd6
  } svf_state_e;

  // Width-independent part of an accepted request.
  typedef struct packed {
    logic signed [15:0] w0;
    logic [10:0]        q;
    logic [2:0]         mode;
    logic [3:0]         vol;
  } svf_req_t;

endpackage

// File: rtl/sid_svf_tdm_if.sv
// rtl/sid_svf_tdm_if.sv - request/result bundle of the TDM state-variable filter
// Purpose: groups the request handshake (in_*, *_i) and result handshake (out_*, audio_o).
// Ports:   master = mixer side (drives requests, consumes results)
//          slave  = filter side
interface sid_svf_tdm_if #(
  parameter int CW = 1,
  parameter int W  = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [CW-1:0]       chan_i;
  logic signed [W-1:0] vi_i;
  logic signed [W-1:0] vd_i;
  logic signed [15:0]  w0_i;
  logic [10:0]         q_i;
  logic [2:0]          mode_i;
  logic [3:0]          vol_i;
  logic                out_valid;
  logic                out_ready;
  logic [CW-1:0]       out_chan;
  logic signed [W+3:0] audio_o;

  modport master (
    output in_valid, chan_i, vi_i, vd_i, w0_i, q_i, mode_i, vol_i, out_ready,
    input  in_ready, out_valid, out_chan, audio_o
  );

  modport slave (
    input  in_valid, chan_i, vi_i, vd_i, w0_i, q_i, mode_i, vol_i, out_ready,
    output in_ready, out_valid, out_chan, audio_o
  );
endinterface

// File: rtl/sid_svf_tdm_mac.sv
// rtl/sid_svf_tdm_mac.sv - shared signed multiply-accumulate, o = c +/- a*b
// Purpose: the single multiplier time-shared by the LP, BP, HP and VOL steps.
// Ports:   a_i   16-bit signed multiplicand
//          b_i   W-bit signed multiplier
//          c_i   (W+32)-bit signed addend
//          sub_i 1 = subtract the product
//          o_o   (W+32)-bit signed result, combinational
module sid_svf_tdm_mac #(
  parameter int W = 16
) (
  input  logic signed [15:0]   a_i,
  input  logic signed [W-1:0]  b_i,
  input  logic signed [W+31:0] c_i,
  input  logic                 sub_i,
  output logic signed [W+31:0] o_o
);
  localparam int PW  = 16 + W;
  localparam int ACC = 32 + W;

  logic signed [PW-1:0] prod;

  assign prod = PW'(a_i) * PW'(b_i);
  assign o_o  = sub_i ? (c_i - ACC'(prod)) : (c_i + ACC'(prod));
endmodule

// File: rtl/sid_svf_tdm.sv
// rtl/sid_svf_tdm.sv - time-multiplexed two-integrator SID state-variable filter
// Purpose: NUM_CH independent LP/BP/HP filter states updated through one shared MAC,
//          one request per handshake, result vol*mix returned on a handshake.
// Ports:   clk, rst_n  clock, synchronous active-low reset
//          bus         sid_svf_tdm_if.slave (request and result handshakes)
//          clip_o      per-channel sticky clamp flags, only when SID_SVF_CLIP_DETECT_EN is defined
module sid_svf_tdm
  import sid_svf_tdm_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int W       = 16,
  parameter int W0_FRAC = SVF_W0_FRAC,
  parameter int Q_FRAC  = SVF_Q_FRAC
) (
  input  logic               clk,
  input  logic               rst_n,
  sid_svf_tdm_if.slave       bus
`ifdef SID_SVF_CLIP_DETECT_EN
  ,
  output logic [NUM_CH-1:0]  clip_o
`endif
);
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC = 32 + W;

  localparam logic [2:0] ST_IDLE = SVF_S_IDLE;
  localparam logic [2:0] ST_LP   = SVF_S_LP;
  localparam logic [2:0] ST_BP   = SVF_S_BP;
  localparam logic [2:0] ST_HP   = SVF_S_HP;
  localparam logic [2:0] ST_MIX  = SVF_S_MIX;
  localparam logic [2:0] ST_VOL  = SVF_S_VOL;
  localparam logic [2:0] ST_OUT  = SVF_S_OUT;

  localparam logic signed [ACC-1:0] SMAX = {{(ACC-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC-1:0] SMIN = {{(ACC-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [CW:0]           NCH  = (CW+1)'(NUM_CH);

  function automatic logic signed [W-1:0] sat(input logic signed [ACC-1:0] x);
    if (x > SMAX)      return SMAX[W-1:0];
    else if (x < SMIN) return SMIN[W-1:0];
    else               return x[W-1:0];
  endfunction

  logic [2:0]          state_q, state_d;
  svf_req_t            req_q;
  logic [CW-1:0]       chan_q;
  logic signed [W-1:0] vi_q, vd_q, mix_q;
  logic signed [W+3:0] audio_q;
  logic [CW-1:0]       out_chan_q;

  logic signed [W-1:0] vlp_q [NUM_CH];
  logic signed [W-1:0] vbp_q [NUM_CH];
  logic signed [W-1:0] vhp_q [NUM_CH];

  logic                chan_ok;
  logic signed [W-1:0] vlp_cur, vbp_cur, vhp_cur;

  logic signed [15:0]    mac_a;
  logic signed [W-1:0]   mac_b;
  logic signed [ACC-1:0] mac_c, mac_o, shr_w0, shr_q;
  logic                  mac_sub;

  logic signed [W+1:0] t_lp, t_bp, t_hp, mix_sum;

  // Out-of-range channels read as zero state and never write back.
  assign chan_ok = ({1'b0, chan_q} < NCH);
  assign vlp_cur = chan_ok ? vlp_q[chan_q] : '0;
  assign vbp_cur = chan_ok ? vbp_q[chan_q] : '0;
  assign vhp_cur = chan_ok ? vhp_q[chan_q] : '0;

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_chan  = out_chan_q;
  assign bus.audio_o   = audio_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_LP;
      ST_LP:   state_d = ST_BP;
      ST_BP:   state_d = ST_HP;
      ST_HP:   state_d = ST_MIX;
      ST_MIX:  state_d = ST_VOL;
      ST_VOL:  state_d = ST_OUT;
      ST_OUT:  if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Integrator steps fold the old state into the addend pre-shifted by the
  // fraction width, so a single floor shift of the MAC result gives
  // v + floor(-w0*x / 2^W0_FRAC). The HP step negates (vlp'+vi) into the addend.
  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_c   = '0;
    mac_sub = 1'b0;
    case (state_q)
      ST_LP: begin
        mac_a   = req_q.w0;
        mac_b   = vbp_cur;
        mac_c   = ACC'(vlp_cur) <<< W0_FRAC;
        mac_sub = 1'b1;
      end
      ST_BP: begin
        mac_a   = req_q.w0;
        mac_b   = vhp_cur;
        mac_c   = ACC'(vbp_cur) <<< W0_FRAC;
        mac_sub = 1'b1;
      end
      ST_HP: begin
        mac_a = {5'b0, req_q.q};
        mac_b = vbp_cur;
        mac_c = -((ACC'(vlp_cur) + ACC'(vi_q)) <<< Q_FRAC);
      end
      ST_VOL: begin
        mac_a = {12'b0, req_q.vol};
        mac_b = mix_q;
      end
      default: ;
    endcase
  end

  sid_svf_tdm_mac #(.W(W)) u_mac (
    .a_i  (mac_a),
    .b_i  (mac_b),
    .c_i  (mac_c),
    .sub_i(mac_sub),
    .o_o  (mac_o)
  );

  assign shr_w0 = mac_o >>> W0_FRAC;
  assign shr_q  = mac_o >>> Q_FRAC;

  always_comb begin
    t_lp    = req_q.mode[SVF_LP] ? (W+2)'(vlp_cur) : '0;
    t_bp    = req_q.mode[SVF_BP] ? (W+2)'(vbp_cur) : '0;
    t_hp    = req_q.mode[SVF_HP] ? (W+2)'(vhp_cur) : '0;
    mix_sum = (W+2)'(vd_q) + t_lp + t_bp + t_hp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      chan_q     <= '0;
      vi_q       <= '0;
      vd_q       <= '0;
      mix_q      <= '0;
      audio_q    <= '0;
      out_chan_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        vlp_q[i] <= '0;
        vbp_q[i] <= '0;
        vhp_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          req_q  <= '{w0: bus.w0_i, q: bus.q_i, mode: bus.mode_i, vol: bus.vol_i};
          chan_q <= bus.chan_i;
          vi_q   <= bus.vi_i;
          vd_q   <= bus.vd_i;
        end
        ST_LP:  if (chan_ok) vlp_q[chan_q] <= sat(shr_w0);
        ST_BP:  if (chan_ok) vbp_q[chan_q] <= sat(shr_w0);
        ST_HP:  if (chan_ok) vhp_q[chan_q] <= sat(shr_q);
        ST_MIX: mix_q <= sat(ACC'(mix_sum));
        ST_VOL: begin
          audio_q    <= chan_ok ? mac_o[W+3:0] : '0;
          out_chan_q <= chan_q;
        end
        default: ;
      endcase
    end
  end

`ifdef SID_SVF_CLIP_DETECT_EN
  logic [NUM_CH-1:0] clip_q;
  logic              sat_hit;

  function automatic logic clamps(input logic signed [ACC-1:0] x);
    return (x > SMAX) || (x < SMIN);
  endfunction

  always_comb begin
    sat_hit = 1'b0;
    case (state_q)
      ST_LP, ST_BP: sat_hit = clamps(shr_w0);
      ST_HP:        sat_hit = clamps(shr_q);
      ST_MIX:       sat_hit = clamps(ACC'(mix_sum));
      default:      sat_hit = 1'b0;
    endcase
  end

  // Set while processing a request; a vol=0 result delivery for the channel clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clip_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (chan_q == CW'(c)) begin
          if (sat_hit)
            clip_q[c] <= 1'b1;
          else if (state_q == ST_OUT && bus.out_ready && req_q.vol == 4'd0)
            clip_q[c] <= 1'b0;
        end
      end
    end
  end

  assign clip_o = clip_q;
`else
  // Clip tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_sid_svf_tdm.sv
// tb/tb_sid_svf_tdm.sv - scoreboard bench for sid_svf_tdm with directed vectors
module tb_sid_svf_tdm;
  localparam int NUM_CH = 3;
  localparam int W      = 16;
  localparam int CW     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_idle = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sid_svf_tdm_if #(.CW(CW), .W(W)) bus ();

`ifdef SID_SVF_CLIP_DETECT_EN
  logic [NUM_CH-1:0] clip;
`endif

  sid_svf_tdm #(.NUM_CH(NUM_CH), .W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef SID_SVF_CLIP_DETECT_EN
    ,
    .clip_o(clip)
`endif
  );

  typedef struct {
    logic [CW-1:0]       chan;
    logic signed [W+3:0] audio;
    int                  acc;
    int                  lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_idle = 1'b0;
    end else begin
      if (chk_idle) begin
        check("in_ready_after_out", bus.in_ready, 1);
        chk_idle = 1'b0;
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", bus.out_valid, 0);
        end else begin
          check("audio_o", bus.audio_o, sb[0].audio);
          check("out_chan", bus.out_chan, sb[0].chan);
          check("in_ready_during_out", bus.in_ready, 0);
          if (bus.out_ready) begin
            check("latency", cyc + 1 - sb[0].acc, sb[0].lat);
            void'(sb.pop_front());
            chk_idle = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input int ch, input int vi, input int vd, input int w0, input int q,
                       input int mode, input int vol, input longint exp_audio,
                       input bit push, input int stall);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", bus.in_ready, 1);
      return;
    end
    bus.chan_i   = CW'(ch);
    bus.vi_i     = W'(vi);
    bus.vd_i     = W'(vd);
    bus.w0_i     = 16'(w0);
    bus.q_i      = 11'(q);
    bus.mode_i   = 3'(mode);
    bus.vol_i    = 4'(vol);
    bus.in_valid = 1'b1;
    if (stall > 0) bus.out_ready = 1'b0;
    if (push) sb.push_back('{CW'(ch), (W+4)'(exp_audio), cyc + 1, 6 + stall});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (stall > 0) begin
      t = 0;
      while (!bus.out_valid && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus.out_valid) check("out_valid_timeout", bus.out_valid, 1);
      repeat (stall) begin
        @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.chan_i    = '0;
    bus.vi_i      = '0;
    bus.vd_i      = '0;
    bus.w0_i      = '0;
    bus.q_i       = '0;
    bus.mode_i    = '0;
    bus.vol_i     = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_audio", bus.audio_o, 0);
    check("reset_out_chan", bus.out_chan, 0);
`ifdef SID_SVF_CLIP_DETECT_EN
    check("reset_clip", clip, 0);
`endif

    //    ch  vi      vd      w0     q     mode vol  expected
    issue(0,  0,      1000,   0,     1024, 0,   15,  15000,   1, 0);
    issue(0, -1000,   0,      0,     1024, 4,   1,   1000,    1, 0);
    issue(0, -1000,   0,      4096,  1024, 4,   1,   968,     1, 0);
    issue(1,  0,      0,      4096,  1024, 7,   1,   0,       1, 0);
    issue(0,  0,      0,      0,     1024, 7,   3,  -192,     1, 0);
    issue(0,  0,      0,      0,     1000, 4,   1,  -32,      1, 0);
    issue(2, -32768,  0,      0,     1024, 4,   1,   32767,   1, 0);
    drain();
`ifdef SID_SVF_CLIP_DETECT_EN
    check("clip_set_ch2", clip[2], 1);
    check("clip_clear_ch0", clip[0], 0);
`endif
    issue(2, -32768,  32767,  0,     1024, 4,   15,  491505,  1, 0);
    issue(2,  0,     -32768,  0,     1024, 1,   15, -491520,  1, 0);
    issue(2,  0,      0,      0,     1024, 0,   0,   0,       1, 0);
    drain();
`ifdef SID_SVF_CLIP_DETECT_EN
    check("clip_cleared_ch2", clip[2], 0);
`endif
    issue(1, -1000,   0,      0,     1024, 4,   1,   1000,    1, 0);
    issue(1,  0,      0,     -4096,  1024, 2,   1,   31,      1, 0);
    issue(1,  0,      0,      0,     512,  4,   1,   15,      1, 3);
    issue(3, -1000,   500,    4096,  1024, 7,   15,  0,       1, 0);
    issue(1,  0,      0,      0,     1024, 2,   1,   31,      1, 0);
    drain();

    // Reset while the request is in BP: no result, all state zeroed.
    issue(0,  0,      0,      4096,  1024, 7,   1,   0,       0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midop_reset_in_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    check("midop_reset_no_out_valid", seen, 0);
    issue(0,  0,      0,      0,     1024, 7,   1,   0,       1, 0);
    issue(1,  0,      0,      0,     1024, 7,   1,   0,       1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
